// File: rtl/mosby_reg_pkg.sv
// Shared definitions for the register-transfer sequencer.
// Contents: data width and flag positions, command op codes, register codes,
// FSM state encoding, command header struct, and legality and enable-decode helpers.
package mosby_reg_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned N_BIT = 7;
  localparam int unsigned Z_BIT = 1;
  localparam int unsigned CODEW = 3;
  localparam int unsigned NREG  = 5;

  // Command op codes; 5-7 are illegal
  localparam logic [CODEW-1:0] OP_NOP = 3'd0;
  localparam logic [CODEW-1:0] OP_MOV = 3'd1;
  localparam logic [CODEW-1:0] OP_LDI = 3'd2;
  localparam logic [CODEW-1:0] OP_INC = 3'd3;
  localparam logic [CODEW-1:0] OP_DEC = 3'd4;

  // Register codes; 5-7 are illegal
  localparam logic [CODEW-1:0] R_A  = 3'd0;
  localparam logic [CODEW-1:0] R_X  = 3'd1;
  localparam logic [CODEW-1:0] R_Y  = 3'd2;
  localparam logic [CODEW-1:0] R_SP = 3'd3;
  localparam logic [CODEW-1:0] R_P  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FLAGS = 2'd3
  } state_e;

  typedef struct packed {
    logic [CODEW-1:0] op;
    logic [CODEW-1:0] src;
    logic [CODEW-1:0] dst;
  } cmd_hdr_t;

  function automatic logic reg_code_ok(input logic [CODEW-1:0] code);
    return (code <= R_P);
  endfunction

  // Only the register codes an op actually uses are checked
  function automatic logic cmd_illegal(input cmd_hdr_t c);
    logic ill;
    ill = 1'b0;
    case (c.op)
      OP_NOP:         ill = 1'b0;
      OP_MOV:         ill = !reg_code_ok(c.src) || !reg_code_ok(c.dst);
      OP_LDI:         ill = !reg_code_ok(c.dst);
      OP_INC, OP_DEC: ill = !reg_code_ok(c.dst) || (c.dst == R_P);
      default:        ill = 1'b1;
    endcase
    return ill;
  endfunction

  // One-hot load enable, bit index equals register code
  function automatic logic [NREG-1:0] con_decode(input logic [CODEW-1:0] code);
    logic [NREG-1:0] con;
    con = '0;
    case (code)
      R_A:     con = 5'b00001;
      R_X:     con = 5'b00010;
      R_Y:     con = 5'b00100;
      R_SP:    con = 5'b01000;
      R_P:     con = 5'b10000;
      default: con = '0;
    endcase
    return con;
  endfunction

endpackage

// File: rtl/reg_alu_lite.sv
// Combinational pass / increment / decrement of an operand with N/Z generation.
// Ports: i_op (command op code), i_operand (value to transform),
//        o_result_c (pass for MOV/LDI, +1 for INC, -1 for DEC, modulo 2^DW),
//        o_n_c (result MSB), o_z_c (result is zero).
module reg_alu_lite #(
  parameter int unsigned DW = 8
) (
  input  logic [2:0]    i_op,
  input  logic [DW-1:0] i_operand,
  output logic [DW-1:0] o_result_c,
  output logic          o_n_c,
  output logic          o_z_c
);
  import mosby_reg_pkg::*;

  // Arithmetic wraps naturally at DW bits
  always_comb begin
    o_result_c = i_operand;
    case (i_op)
      OP_INC:  o_result_c = i_operand + DW'(1);
      OP_DEC:  o_result_c = i_operand - DW'(1);
      default: o_result_c = i_operand;
    endcase
    o_n_c = o_result_c[DW-1];
    o_z_c = (o_result_c == '0);
  end

endmodule

// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer for the CPU register file (A, X, Y, SP, P).
// Accepts one command at a time over valid/ready, reads the operand from the
// register file, drives data_in / data_status and a single load enable, then
// optionally rewrites N/Z in P.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready handshake with
//        cmd_op, cmd_src, cmd_dst, cmd_imm; data_out_* current register values;
//        data_in (A/X/Y/SP write data), data_status (P write data);
//        x_con, y_con, accumulator_con, stack_pointer_con, status_con load enables;
//        busy, done (retire pulse), err (illegal-command pulse with done).
module reg_xfer_seq #(
  parameter int unsigned DW    = 8,
  parameter int unsigned N_BIT = 7,
  parameter int unsigned Z_BIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [2:0]    cmd_src,
  input  logic [2:0]    cmd_dst,
  input  logic [DW-1:0] cmd_imm,
  input  logic [DW-1:0] data_out_x,
  input  logic [DW-1:0] data_out_y,
  input  logic [DW-1:0] data_out_accumulator,
  input  logic [DW-1:0] data_out_sp,
  input  logic [DW-1:0] data_out_status,
  output logic [DW-1:0] data_in,
  output logic [DW-1:0] data_status,
  output logic          x_con,
  output logic          y_con,
  output logic          accumulator_con,
  output logic          stack_pointer_con,
  output logic          status_con,
  output logic          busy,
  output logic          done,
  output logic          err
);
  import mosby_reg_pkg::*;

  state_e          r_state;
  cmd_hdr_t        r_hdr;
  logic [DW-1:0]   r_imm;
  logic            r_n;
  logic            r_z;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [DW-1:0]   r_data_in;
  logic [DW-1:0]   r_data_status;
  logic [NREG-1:0] r_con;

  state_e          w_state_nxt;
  logic            w_ready_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_err_nxt;
  logic [DW-1:0]   w_data_in_nxt;
  logic [DW-1:0]   w_data_status_nxt;
  logic [NREG-1:0] w_con_nxt;
  logic            w_latch_cmd;
  logic            w_latch_res;

  logic [2:0]      w_rd_code;
  logic [DW-1:0]   w_rd_val;
  logic [DW-1:0]   w_operand;
  logic [DW-1:0]   w_result;
  logic            w_n;
  logic            w_z;
  logic            w_illegal;
  logic            w_flag_due;
  logic [DW-1:0]   w_flag_status;

  // Operand select: MOV reads src, INC/DEC read dst, LDI takes the immediate
  always_comb begin
    w_rd_code = (r_hdr.op == OP_MOV) ? r_hdr.src : r_hdr.dst;
    case (w_rd_code)
      R_A:     w_rd_val = data_out_accumulator;
      R_X:     w_rd_val = data_out_x;
      R_Y:     w_rd_val = data_out_y;
      R_SP:    w_rd_val = data_out_sp;
      R_P:     w_rd_val = data_out_status;
      default: w_rd_val = '0;
    endcase
    w_operand = (r_hdr.op == OP_LDI) ? r_imm : w_rd_val;
  end

  // The result is formed during FETCH so data_in can be a register during EXEC
  reg_alu_lite #(
    .DW(DW)
  ) u_alu (
    .i_op       (r_hdr.op),
    .i_operand  (w_operand),
    .o_result_c (w_result),
    .o_n_c      (w_n),
    .o_z_c      (w_z)
  );

  assign w_illegal  = cmd_illegal(r_hdr);
  assign w_flag_due = (r_hdr.dst == R_A) || (r_hdr.dst == R_X) || (r_hdr.dst == R_Y);

  // N/Z merged into the P value seen live in the FLAGS cycle
  always_comb begin
    w_flag_status        = data_out_status;
    w_flag_status[N_BIT] = r_n;
    w_flag_status[Z_BIT] = r_z;
  end

  // State register plus all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_hdr         <= '0;
      r_imm         <= '0;
      r_n           <= 1'b0;
      r_z           <= 1'b0;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_data_in     <= '0;
      r_data_status <= '0;
      r_con         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ready       <= w_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_data_in     <= w_data_in_nxt;
      r_data_status <= w_data_status_nxt;
      r_con         <= w_con_nxt;
      if (w_latch_cmd) begin
        r_hdr <= '{op: cmd_op, src: cmd_src, dst: cmd_dst};
        r_imm <= cmd_imm;
      end
      if (w_latch_res) begin
        r_n <= w_n;
        r_z <= w_z;
      end
    end
  end

  // Next state and next registered outputs; enables are set one edge ahead
  always_comb begin
    w_state_nxt       = r_state;
    w_ready_nxt       = 1'b0;
    w_busy_nxt        = 1'b1;
    w_done_nxt        = 1'b0;
    w_err_nxt         = 1'b0;
    w_data_in_nxt     = r_data_in;
    w_data_status_nxt = r_data_status;
    w_con_nxt         = '0;
    w_latch_cmd       = 1'b0;
    w_latch_res       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (cmd_valid && r_ready) begin
          w_state_nxt = S_FETCH;
          w_latch_cmd = 1'b1;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end

      S_FETCH: begin
        if (w_illegal || (r_hdr.op == OP_NOP)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = w_illegal;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_EXEC;
          w_latch_res = 1'b1;
          w_con_nxt   = con_decode(r_hdr.dst);
          if (r_hdr.dst == R_P) begin
            w_data_status_nxt = w_result;
          end else begin
            w_data_in_nxt = w_result;
          end
        end
      end

      S_EXEC: begin
        if (w_flag_due) begin
          w_state_nxt = S_FLAGS;
          w_con_nxt   = con_decode(R_P);
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end

      S_FLAGS: begin
        w_state_nxt       = S_IDLE;
        w_done_nxt        = 1'b1;
        w_ready_nxt       = 1'b1;
        w_busy_nxt        = 1'b0;
        w_data_status_nxt = w_flag_status;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign cmd_ready         = r_ready;
  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;
  assign data_in           = r_data_in;
  assign data_status       = (r_state == S_FLAGS) ? w_flag_status : r_data_status;
  assign accumulator_con   = r_con[R_A];
  assign x_con             = r_con[R_X];
  assign y_con             = r_con[R_Y];
  assign stack_pointer_con = r_con[R_SP];
  assign status_con        = r_con[R_P];

endmodule
